// File: rtl/mbssoc_ram_responder_pkg.sv
// ---------------------------------------------------------------------------
// mbssoc_ram_responder_pkg
// Shared constants for the SoC RAM responder slice: default bus widths,
// default array depth and wait states, wait-counter width and the FSM state
// encoding used by mbssoc_ram_responder.
// ---------------------------------------------------------------------------
package mbssoc_ram_responder_pkg;

  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int DEPTH_LOG2_DEF  = 10;
  localparam int WAIT_CYCLES_DEF = 1;

  // Wait states range over 0..15, so four bits hold the counter.
  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mbssoc_ram_responder_array.sv
// ---------------------------------------------------------------------------
// mbssoc_ram_array
// Single-port word-organised on-chip RAM: synchronous write, combinational
// read from the same index. Contents are never reset.
// Ports:
//   clk      in  rising-edge clock
//   i_we     in  write enable, commits i_wdata at i_idx on the clock edge
//   i_idx    in  word index (DEPTH_LOG2 bits)
//   i_wdata  in  write data
//   o_rdata  out combinational read data at i_idx
// ---------------------------------------------------------------------------
module mbssoc_ram_array
  import mbssoc_ram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  // Storage write port; no reset so the array maps onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mbssoc_ram_responder.sv
// ---------------------------------------------------------------------------
// mbssoc_ram_responder
// Memory-side responder for the shared SoC RAM port behind the core-bus
// arbiter. Accepts one read or write in IDLE, spends WAIT_CYCLES cycles in
// WAIT, then spends exactly one cycle in RESP pulsing ram_rvalid or ram_wack.
// ram_busy is high whenever the FSM is not IDLE so the arbiter can stall.
// Optional feature macro: MBSSOC_RAM_ERR_EN (out-of-range and re&we error
// reporting on ram_err; without it upper address bits alias and ram_err=0).
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   ram_re / ram_we          level requests from the arbiter
//   ram_addr / ram_wdata     byte address and write data, latched on accept
//   ram_busy                 high while an access is in progress
//   ram_rdata / ram_rvalid   read data and one-cycle read-response pulse
//   ram_wack                 one-cycle write-commit pulse
//   ram_err                  error pulse alongside the response
// ---------------------------------------------------------------------------
module mbssoc_ram_responder
  import mbssoc_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_re,
  input  logic                  ram_we,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_busy,
  output logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ram_rvalid,
  output logic                  ram_wack,
  output logic                  ram_err
);

  localparam logic [CNT_WIDTH-1:0] W_WAIT  = CNT_WIDTH'(WAIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                r_state;
  state_t                w_nextState;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_isWrite;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_oor;
  logic                  r_dual;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_wack;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_enterResp;
  logic                  w_oor;
  logic                  w_dual;
  logic                  w_opWrite;
  logic [DEPTH_LOG2-1:0] w_opIdx;
  logic [DATA_WIDTH-1:0] w_opWdata;
  logic                  w_opOor;
  logic                  w_opDual;
  logic                  w_memWe;
  logic [DATA_WIDTH-1:0] w_memRdata;
  logic                  w_unused;

`ifdef MBSSOC_RAM_ERR_EN
  // Any address bit above the word index makes the access out of range.
  assign w_oor  = |ram_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign w_dual = ram_re & ram_we;
`else
  assign w_oor  = 1'b0;
  assign w_dual = 1'b0;
`endif

  // Byte-lane bits are ignored (word access only); upper bits alias unless
  // error reporting is compiled in.
  assign w_unused = ^{ram_addr[1:0], ram_addr[ADDR_WIDTH-1:DEPTH_LOG2+2]};

  assign w_accept = (r_state == ST_IDLE) && (ram_re || ram_we);

  // With zero wait states RESP is entered straight from IDLE, before the
  // request latches have loaded, so the live bus feeds the array that cycle.
  assign w_opWrite = w_accept ? ram_we : r_isWrite;
  assign w_opIdx   = w_accept ? ram_addr[DEPTH_LOG2+1:2] : r_idx;
  assign w_opWdata = w_accept ? ram_wdata : r_wdata;
  assign w_opOor   = w_accept ? w_oor : r_oor;
  assign w_opDual  = w_accept ? w_dual : r_dual;

  // The write commits on the edge entering RESP; a reset on that edge
  // drops it, and out-of-range writes never reach the array.
  assign w_memWe = w_enterResp && w_opWrite && !w_opOor && !rst;

  mbssoc_ram_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_memWe),
    .i_idx   (w_opIdx),
    .i_wdata (w_opWdata),
    .o_rdata (w_memRdata)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. w_enterResp marks the edge on which the response
  // flops load and a write commits.
  always_comb begin
    w_nextState = r_state;
    w_enterResp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ram_re || ram_we) begin
          if (W_WAIT == '0) begin
            w_nextState = ST_RESP;
            w_enterResp = 1'b1;
          end else begin
            w_nextState = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == W_WAIT) begin
          w_nextState = ST_RESP;
          w_enterResp = 1'b1;
        end
      end
      ST_RESP: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Wait counter and response pulses. The counter reads 1 in the first WAIT
  // cycle; ram_rdata only changes on a read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_wack   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_wack   <= 1'b0;
      r_err    <= 1'b0;
      if (w_enterResp) begin
        r_cnt <= '0;
        r_err <= w_opOor | w_opDual;
        if (w_opWrite) begin
          r_wack <= 1'b1;
        end else begin
          r_rvalid <= 1'b1;
          r_rdata  <= w_opOor ? '0 : w_memRdata;
        end
      end else if (w_accept) begin
        r_cnt <= CNT_ONE;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  // Request latches, loaded only on accept so later bus activity cannot
  // disturb an access in flight.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_isWrite <= ram_we;
      r_idx     <= ram_addr[DEPTH_LOG2+1:2];
      r_wdata   <= ram_wdata;
      r_oor     <= w_oor;
      r_dual    <= w_dual;
    end
  end

  assign ram_busy   = (r_state != ST_IDLE);
  assign ram_rdata  = r_rdata;
  assign ram_rvalid = r_rvalid;
  assign ram_wack   = r_wack;
  assign ram_err    = r_err;

endmodule

// File: tb/tb_mbssoc_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_mbssoc_ram_responder
// Directed bench for mbssoc_ram_responder. Two instances share the request
// bus: u_dut1 (WAIT_CYCLES=1) and u_dut0 (WAIT_CYCLES=0); 'sel' steers the
// requests and the observed outputs to one of them. Expected responses are
// queued when a request is driven and popped when a pulse appears.
// Honours MBSSOC_RAM_ERR_EN for the expected ram_err / out-of-range data.
// ---------------------------------------------------------------------------
module tb_mbssoc_ram_responder;

`ifdef MBSSOC_RAM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        isRead;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        sel;

  logic        busy1, rvalid1, wack1, err1;
  logic [31:0] rdata1;
  logic        busy0, rvalid0, wack0, err0;
  logic [31:0] rdata0;

  logic        busyM, rvalidM, wackM, errM;
  logic [31:0] rdataM;

  exp_t expQ[$];
  int   nCompared;
  int   nMismatch;

  mbssoc_ram_responder #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH_LOG2 (10), .WAIT_CYCLES (1)
  ) u_dut1 (
    .clk (clk), .rst (rst),
    .ram_re (re & sel), .ram_we (we & sel),
    .ram_addr (addr), .ram_wdata (wdata),
    .ram_busy (busy1), .ram_rdata (rdata1), .ram_rvalid (rvalid1),
    .ram_wack (wack1), .ram_err (err1)
  );

  mbssoc_ram_responder #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH_LOG2 (10), .WAIT_CYCLES (0)
  ) u_dut0 (
    .clk (clk), .rst (rst),
    .ram_re (re & ~sel), .ram_we (we & ~sel),
    .ram_addr (addr), .ram_wdata (wdata),
    .ram_busy (busy0), .ram_rdata (rdata0), .ram_rvalid (rvalid0),
    .ram_wack (wack0), .ram_err (err0)
  );

  assign busyM   = sel ? busy1   : busy0;
  assign rvalidM = sel ? rvalid1 : rvalid0;
  assign wackM   = sel ? wack1   : wack0;
  assign errM    = sel ? err1    : err0;
  assign rdataM  = sel ? rdata1  : rdata0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on a miss counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expected response and compares it with the pulse now visible.
  task automatic checkResponse();
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput("sbUnexpectedResp", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput("respRvalid", {31'd0, rvalidM}, {31'd0, e.isRead});
      checkOutput("respWack", {31'd0, wackM}, {31'd0, ~e.isRead});
      checkOutput("respErr", {31'd0, errM}, {31'd0, e.err});
      if (e.isRead) checkOutput("respRdata", rdataM, e.data);
    end
  endtask

  // One complete access on the selected instance: request held for a single
  // accept edge, bus scrambled afterwards, latency and pulse width checked.
  task automatic applyStimulus(input logic iRe, input logic iWe,
                               input logic [31:0] iAddr, input logic [31:0] iWdata,
                               input logic expRead, input logic [31:0] expData,
                               input logic expErr);
    int lat;
    @(negedge clk);
    checkOutput("busyIdle", {31'd0, busyM}, 32'd0);
    re = iRe; we = iWe; addr = iAddr; wdata = iWdata;
    expQ.push_back({expRead, expData, expErr});
    @(posedge clk);
    @(negedge clk);
    re = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFC; wdata = 32'hBAD0_BAD0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) checkOutput("busyAfterAccept", {31'd0, busyM}, 32'd1);
      if (rvalidM || wackM) begin
        lat = k;
        checkOutput("busyInResp", {31'd0, busyM}, 32'd1);
        checkResponse();
        break;
      end
    end
    checkOutput("latency", lat, sel ? 32'd2 : 32'd1);
    @(negedge clk);
    checkOutput("pulseOneCycle", {30'd0, rvalidM, wackM}, 32'd0);
    checkOutput("busyBackIdle", {31'd0, busyM}, 32'd0);
  endtask

  initial begin
    int   p1, p2, extra;
    logic gapBusy, sawWack;

    nCompared = 0;
    nMismatch = 0;
    sel = 1'b1; rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy1", {31'd0, busy1}, 32'd0);
    checkOutput("rstRdata1", rdata1, 32'd0);
    checkOutput("rstPulses1", {29'd0, rvalid1, wack1, err1}, 32'd0);
    checkOutput("rstBusy0", {31'd0, busy0}, 32'd0);
    checkOutput("rstPulses0", {29'd0, rvalid0, wack0, err0}, 32'd0);
    rst = 1'b0;

    // One wait state: write then read back.
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h8, 32'hAAAA_5555, 1'b0, 32'h0, 1'b0);

    // Reset during WAIT of a write drops the write and clears all outputs.
    @(negedge clk);
    we = 1'b1; addr = 32'h8; wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    checkOutput("rstMidBusy", {31'd0, busyM}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstMidBusyClr", {31'd0, busyM}, 32'd0);
    checkOutput("rstMidRdataClr", rdataM, 32'd0);
    checkOutput("rstMidPulses", {29'd0, rvalidM, wackM, errM}, 32'd0);
    rst = 1'b0;
    sawWack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sawWack = sawWack | wackM;
    end
    checkOutput("rstNoWack", {31'd0, sawWack}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'hAAAA_5555, 1'b0);

    // re and we together: a write that commits, error only with the macro.
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h5, 1'b0, 32'h0, ERR_EN);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h5, 1'b0);

    // Out-of-range address: suppressed with the macro, aliases to 0x0 without.
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0F0F_0F0F, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h1000, 32'hCAFE_F00D, 1'b0, 32'h0, ERR_EN);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1,
                  ERR_EN ? 32'h0F0F_0F0F : 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h1000, 32'h0, 1'b1,
                  ERR_EN ? 32'h0 : 32'hCAFE_F00D, ERR_EN);

    // Zero wait states: preload, then back-to-back reads with re held high.
    sel = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h2222_2222, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    re = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    expQ.push_back({1'b1, 32'h1111_1111, 1'b0});
    expQ.push_back({1'b1, 32'h2222_2222, 1'b0});
    p1 = 0; p2 = 0; extra = 0; gapBusy = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (p1 != 0 && k == p1 + 1) gapBusy = busyM;
      if (rvalidM || wackM) begin
        if (p1 == 0) begin
          p1 = k;
          checkResponse();
          addr = 32'h4;
        end else if (p2 == 0) begin
          p2 = k;
          checkResponse();
          re = 1'b0;
        end else begin
          extra++;
        end
      end
    end
    re = 1'b0;
    checkOutput("b2bFirstLatency", p1, 32'd1);
    checkOutput("b2bSpacing", p2 - p1, 32'd2);
    checkOutput("b2bIdleGap", {31'd0, gapBusy}, 32'd0);
    checkOutput("b2bNoExtra", extra, 32'd0);
    checkOutput("sbDrained", expQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
